// File: rtl/fpu_fwd_pkg.sv
// Shared types, default configuration and the youngest-match helper
// for the FPU forwarding tracker.
package fpu_fwd_pkg;

    localparam int unsigned NSRC_DEF  = 3;
    localparam int unsigned DEPTH_DEF = 6;
    localparam int unsigned REG_W_DEF = 5;
    localparam int unsigned LAT_W_DEF = 3;

    // Widest stage vector the youngest-match helper can handle.
    localparam int unsigned MAX_DEPTH = 32;

    // In-flight entry for the default configuration; the top declares the
    // same layout with its own parameter widths.
    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] rd;
        logic [LAT_W_DEF-1:0] lat;
    } fwd_entry_t;

    // Isolate the lowest set bit: bit 0 is stage 1, so this is the youngest match.
    function automatic logic [MAX_DEPTH-1:0] youngest_onehot(input logic [MAX_DEPTH-1:0] match);
        return match & (~match + MAX_DEPTH'(1));
    endfunction

endpackage

// File: rtl/fpu_fwd_match.sv
// Per-operand priority match against the in-flight stages plus the
// result-ready check of the selected producer. Purely combinational.
module fpu_fwd_match
    import fpu_fwd_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned LAT_W = LAT_W_DEF
) (
    input  logic [REG_W-1:0]            rs_idx,
    input  logic                        rs_en,
    input  logic [DEPTH-1:0]            stage_valid,
    input  logic [DEPTH-1:0][REG_W-1:0] stage_rd,
    input  logic [DEPTH-1:0][LAT_W-1:0] stage_lat,
    output logic                        hit,
    output logic [DEPTH-1:0]            sel,
    output logic                        pending
);

    logic [DEPTH-1:0]     match;
    logic [DEPTH-1:0]     ready;
    logic [DEPTH-1:0]     youngest;
    logic [MAX_DEPTH-1:0] match_ext;
    logic [MAX_DEPTH-1:0] youngest_ext;
    logic [MAX_DEPTH-1:0] unused_youngest;

    // Per-stage tag match and whether that stage's result already exists (k >= lat).
    always_comb begin
        match = '0;
        ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = rs_en & stage_valid[k] & (stage_rd[k] == rs_idx);
            ready[k] = (stage_lat[k] <= LAT_W'(k + 1));
        end
    end

    assign match_ext       = MAX_DEPTH'(match);
    assign youngest_ext    = youngest_onehot(match_ext);
    assign youngest        = youngest_ext[DEPTH-1:0];
    assign unused_youngest = youngest_ext;

    // Only the youngest producer counts; an older ready copy never hides a pending one.
    assign hit     = |(youngest & ready);
    assign pending = |(youngest & ~ready);
    assign sel     = hit ? youngest : '0;

endmodule

// File: rtl/fpu_forward_tracker.sv
// In-flight destination-tag pipeline for the FPU with per-operand forward
// selects, RAW stall generation, occupancy and write-back tag outputs.
module fpu_forward_tracker
    import fpu_fwd_pkg::*;
#(
    parameter int unsigned NSRC  = NSRC_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned LAT_W = LAT_W_DEF,
    parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NSRC*REG_W-1:0]   rs_idx,
    input  logic [NSRC-1:0]         rs_en,
    input  logic                    issue_valid,
    input  logic                    issue_wr,
    input  logic [REG_W-1:0]        issue_rd,
    input  logic [LAT_W-1:0]        issue_lat,
    input  logic                    flush,
    output logic [NSRC-1:0]         fwd_hit,
    output logic [NSRC*DEPTH-1:0]   fwd_sel,
    output logic                    stall,
    output logic                    issue_fire,
    output logic                    wb_valid,
    output logic [REG_W-1:0]        wb_rd,
    output logic [OCC_W-1:0]        occupancy
);

    // Index k-1 holds stage k.
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][REG_W-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][LAT_W-1:0] lat_q, lat_d;
    logic [OCC_W-1:0]            occ_q, occ_d;
    logic [NSRC-1:0]             pending;
    logic                        load;

    for (genvar s = 0; s < NSRC; s++) begin : g_match
        fpu_fwd_match #(
            .DEPTH(DEPTH),
            .REG_W(REG_W),
            .LAT_W(LAT_W)
        ) u_match (
            .rs_idx     (rs_idx[s*REG_W +: REG_W]),
            .rs_en      (rs_en[s]),
            .stage_valid(valid_q),
            .stage_rd   (rd_q),
            .stage_lat  (lat_q),
            .hit        (fwd_hit[s]),
            .sel        (fwd_sel[s*DEPTH +: DEPTH]),
            .pending    (pending[s])
        );
    end

    assign stall      = issue_valid & (|pending);
    assign issue_fire = issue_valid & ~stall & ~flush;
    assign load       = issue_fire & issue_wr;

    // Shift the stage pipeline, load stage 1 (bubble unless a writer fires), count survivors.
    always_comb begin
        valid_d    = '0;
        rd_d       = '0;
        lat_d      = '0;
        valid_d[0] = load;
        rd_d[0]    = load ? issue_rd : '0;
        lat_d[0]   = load ? issue_lat : '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
            lat_d[k]   = lat_q[k-1];
        end
        if (flush) begin
            valid_d = '0;
        end
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    // Stage registers and occupancy; reset discards every entry at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            rd_q    <= '0;
            lat_q   <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            lat_q   <= lat_d;
            occ_q   <= occ_d;
        end
    end

    assign wb_valid  = valid_q[DEPTH-1];
    assign wb_rd     = rd_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_fpu_forward_tracker.sv
// Scenario bench for fpu_forward_tracker: per-cycle stimulus rows with
// expected outputs queued as a scoreboard and compared once settled.
module tb_fpu_forward_tracker;

    localparam int unsigned NSRC  = 3;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned REG_W = 5;
    localparam int unsigned LAT_W = 3;
    localparam int unsigned OCC_W = 3;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [NSRC*REG_W-1:0] rs_idx = '0;
    logic [NSRC-1:0]       rs_en = '0;
    logic                  issue_valid = 1'b0;
    logic                  issue_wr = 1'b0;
    logic [REG_W-1:0]      issue_rd = '0;
    logic [LAT_W-1:0]      issue_lat = '0;
    logic                  flush = 1'b0;
    logic [NSRC-1:0]       fwd_hit;
    logic [NSRC*DEPTH-1:0] fwd_sel;
    logic                  stall;
    logic                  issue_fire;
    logic                  wb_valid;
    logic [REG_W-1:0]      wb_rd;
    logic [OCC_W-1:0]      occupancy;

    fpu_forward_tracker #(
        .NSRC (NSRC),
        .DEPTH(DEPTH),
        .REG_W(REG_W),
        .LAT_W(LAT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rs_idx     (rs_idx),
        .rs_en      (rs_en),
        .issue_valid(issue_valid),
        .issue_wr   (issue_wr),
        .issue_rd   (issue_rd),
        .issue_lat  (issue_lat),
        .flush      (flush),
        .fwd_hit    (fwd_hit),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .issue_fire (issue_fire),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iv;
        logic       wr;
        logic [4:0] rd;
        logic [2:0] lat;
        logic       fl;
        logic [2:0] en;
        logic [4:0] i2;
        logic [4:0] i1;
        logic [4:0] i0;
    } stim_t;

    typedef struct packed {
        logic [2:0]  hit;
        logic [17:0] sel;
        logic        stl;
        logic        fire;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [2:0]  occ;
    } out_t;

    localparam stim_t IDLE = '0;

    out_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic stim_t stim(input logic iv, input logic wr, input logic [4:0] rd,
                                   input logic [2:0] lat, input logic fl, input logic [2:0] en,
                                   input logic [4:0] i2, input logic [4:0] i1,
                                   input logic [4:0] i0);
        return {iv, wr, rd, lat, fl, en, i2, i1, i0};
    endfunction

    function automatic out_t expv(input logic [2:0] hit, input logic [5:0] s2,
                                  input logic [5:0] s1, input logic [5:0] s0, input logic stl,
                                  input logic fire, input logic wbv, input logic [4:0] wbrd,
                                  input logic [2:0] occ);
        return {hit, s2, s1, s0, stl, fire, wbv, wbrd, occ};
    endfunction

    function automatic out_t observe();
        return {fwd_hit, fwd_sel, stall, issue_fire, wb_valid, wb_rd, occupancy};
    endfunction

    // wb_rd is only meaningful with wb_valid; fire is not judged while reset is held.
    function automatic out_t care(input out_t e, input logic fire_known);
        out_t m;
        m = '1;
        if (!e.wbv) m.wbrd = '0;
        if (!fire_known) m.fire = 1'b0;
        return m;
    endfunction

    task automatic drive(input stim_t s);
        issue_valid = s.iv;
        issue_wr    = s.wr;
        issue_rd    = s.rd;
        issue_lat   = s.lat;
        flush       = s.fl;
        rs_en       = s.en;
        rs_idx      = {s.i2, s.i1, s.i0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(IDLE);
        repeat (DEPTH) tick();
    endtask

    // Legal writers must carry a latency in 1..DEPTH.
    always @(posedge clk) begin
        if (rstn && issue_valid && issue_wr && !flush) begin
            assert (int'(issue_lat) >= 1 && int'(issue_lat) <= int'(DEPTH))
            else $error("FAIL illegal_lat: got lat=%0d want 1..%0d", issue_lat, DEPTH);
        end
    end

    task automatic test_reset();
        stim_t s[$];
        out_t  x[$];
        out_t  e, g, m;
        s.push_back(stim(1'b1, 1'b1, 5'd4, 3'd1, '0, 3'b111, 5'd4, 5'd4, 5'd4));
        x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, '0));
        s.push_back(stim(1'b1, 1'b1, 5'd4, 3'd1, '0, 3'b111, 5'd4, 5'd4, 5'd4));
        x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, '0));
        s.push_back(stim(1'b1, 1'b1, 5'd4, 3'd1, '0, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, '0));
        s.push_back(stim('0, '0, '0, '0, '0, 3'b001, '0, '0, 5'd4));
        x.push_back(expv(3'b001, '0, '0, 6'b000001, '0, '0, '0, '0, 3'd1));
        rstn = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            if (i == 2) rstn = 1'b1;
            drive(s[i]);
            sb.push_back(x[i]);
            #2;
            e = sb.pop_front();
            g = observe();
            m = care(e, i >= 2);
            n_cmp++;
            if ((g & m) !== (e & m)) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h want %h (care %h)", i, g, e, m);
            end
            tick();
        end
    endtask

    task automatic test_latency_stall();
        stim_t s[$];
        out_t  x[$];
        out_t  e, g, m;
        s.push_back(stim(1'b1, 1'b1, 5'd7, 3'd3, '0, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, '0));
        for (int i = 0; i < 2; i++) begin
            s.push_back(stim(1'b1, 1'b1, 5'd8, 3'd1, '0, 3'b001, '0, '0, 5'd7));
            x.push_back(expv('0, '0, '0, '0, 1'b1, '0, '0, '0, 3'd1));
        end
        s.push_back(stim(1'b1, 1'b1, 5'd8, 3'd1, '0, 3'b001, '0, '0, 5'd7));
        x.push_back(expv(3'b001, '0, '0, 6'b000100, '0, 1'b1, '0, '0, 3'd1));
        s.push_back(IDLE);
        x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, 3'd2));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            #2;
            e = sb.pop_front();
            g = observe();
            m = care(e, 1'b1);
            n_cmp++;
            if ((g & m) !== (e & m)) begin
                n_err++;
                $display("FAIL latency_stall[%0d]: got %h want %h (care %h)", i, g, e, m);
            end
            tick();
        end
    endtask

    task automatic test_unused_operand();
        stim_t s[$];
        out_t  x[$];
        out_t  e, g, m;
        s.push_back(stim(1'b1, 1'b1, 5'd7, 3'd5, '0, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, '0));
        s.push_back(stim(1'b1, '0, '0, '0, '0, 3'b011, 5'd7, 5'd3, 5'd0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, 3'd1));
        s.push_back(stim(1'b1, '0, '0, '0, '0, 3'b100, 5'd7, 5'd3, 5'd0));
        x.push_back(expv('0, '0, '0, '0, 1'b1, '0, '0, '0, 3'd1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            #2;
            e = sb.pop_front();
            g = observe();
            m = care(e, 1'b1);
            n_cmp++;
            if ((g & m) !== (e & m)) begin
                n_err++;
                $display("FAIL unused_operand[%0d]: got %h want %h (care %h)", i, g, e, m);
            end
            tick();
        end
    endtask

    task automatic test_youngest();
        stim_t s[$];
        out_t  x[$];
        out_t  e, g, m;
        s.push_back(stim(1'b1, 1'b1, 5'd2, 3'd1, '0, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, '0));
        s.push_back(stim(1'b1, 1'b1, 5'd2, 3'd1, '0, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, 3'd1));
        s.push_back(stim(1'b1, 1'b1, 5'd5, 3'd1, '0, 3'b010, '0, 5'd2, '0));
        x.push_back(expv(3'b010, '0, 6'b000001, '0, '0, 1'b1, '0, '0, 3'd2));
        s.push_back(stim(1'b1, 1'b1, 5'd5, 3'd4, '0, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, 3'd3));
        // Youngest f5 is not ready although an older f5 is: must stall.
        s.push_back(stim(1'b1, 1'b1, 5'd0, 3'd1, '0, 3'b001, '0, '0, 5'd5));
        x.push_back(expv('0, '0, '0, '0, 1'b1, '0, '0, '0, 3'd4));
        s.push_back(stim(1'b1, 1'b1, 5'd0, 3'd1, '0, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, 3'd4));
        // f0 forwards like any other register.
        s.push_back(stim('0, '0, '0, '0, '0, 3'b100, 5'd0, 5'd0, 5'd0));
        x.push_back(expv(3'b100, 6'b000001, '0, '0, '0, '0, 1'b1, 5'd2, 3'd5));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            #2;
            e = sb.pop_front();
            g = observe();
            m = care(e, 1'b1);
            n_cmp++;
            if ((g & m) !== (e & m)) begin
                n_err++;
                $display("FAIL youngest[%0d]: got %h want %h (care %h)", i, g, e, m);
            end
            tick();
        end
    endtask

    task automatic test_drain();
        stim_t s[$];
        out_t  x[$];
        out_t  e, g, m;
        s.push_back(stim(1'b1, 1'b1, 5'd9, 3'd6, '0, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, '0));
        for (int i = 0; i < 5; i++) begin
            s.push_back(IDLE);
            x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, 3'd1));
        end
        s.push_back(stim(1'b1, '0, '0, '0, '0, 3'b001, '0, '0, 5'd9));
        x.push_back(expv(3'b001, '0, '0, 6'b100000, '0, 1'b1, 1'b1, 5'd9, 3'd1));
        s.push_back(IDLE);
        x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, '0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            #2;
            e = sb.pop_front();
            g = observe();
            m = care(e, 1'b1);
            n_cmp++;
            if ((g & m) !== (e & m)) begin
                n_err++;
                $display("FAIL drain[%0d]: got %h want %h (care %h)", i, g, e, m);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        out_t  x[$];
        out_t  e, g, m;
        for (int i = 0; i < 6; i++) begin
            s.push_back(stim(1'b1, 1'b1, 5'(i + 1), 3'd1, '0, '0, '0, '0, '0));
            x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, 3'(i)));
        end
        s.push_back(stim(1'b1, 1'b1, 5'd7, 3'd2, '0, 3'b111, 5'd3, 5'd6, 5'd1));
        x.push_back(expv(3'b111, 6'b001000, 6'b000001, 6'b100000, '0, 1'b1, 1'b1, 5'd1, 3'd6));
        s.push_back(IDLE);
        x.push_back(expv('0, '0, '0, '0, '0, '0, 1'b1, 5'd2, 3'd6));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            #2;
            e = sb.pop_front();
            g = observe();
            m = care(e, 1'b1);
            n_cmp++;
            if ((g & m) !== (e & m)) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %h want %h (care %h)", i, g, e, m);
            end
            tick();
        end
    endtask

    // Runs with the pipeline still full from test_back_to_back.
    task automatic test_mid_reset();
        stim_t s[$];
        out_t  x[$];
        out_t  e, g, m;
        s.push_back(stim(1'b1, '0, '0, '0, '0, 3'b001, '0, '0, 5'd7));
        x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, '0));
        s.push_back(stim('0, '0, '0, '0, '0, 3'b001, '0, '0, 5'd7));
        x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, '0));
        for (int i = 0; i < s.size(); i++) begin
            rstn = (i != 0);
            drive(s[i]);
            sb.push_back(x[i]);
            #2;
            e = sb.pop_front();
            g = observe();
            m = care(e, i != 0);
            n_cmp++;
            if ((g & m) !== (e & m)) begin
                n_err++;
                $display("FAIL mid_reset[%0d]: got %h want %h (care %h)", i, g, e, m);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        out_t  x[$];
        out_t  e, g, m;
        for (int i = 0; i < 3; i++) begin
            s.push_back(stim(1'b1, 1'b1, 5'(10 + i), 3'd6, '0, '0, '0, '0, '0));
            x.push_back(expv('0, '0, '0, '0, '0, 1'b1, '0, '0, 3'(i)));
        end
        s.push_back(stim(1'b1, 1'b1, 5'd13, 3'd1, 1'b1, '0, '0, '0, '0));
        x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, 3'd3));
        for (int i = 0; i < 6; i++) begin
            s.push_back(IDLE);
            x.push_back(expv('0, '0, '0, '0, '0, '0, '0, '0, '0));
        end
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            #2;
            e = sb.pop_front();
            g = observe();
            m = care(e, 1'b1);
            n_cmp++;
            if ((g & m) !== (e & m)) begin
                n_err++;
                $display("FAIL flush[%0d]: got %h want %h (care %h)", i, g, e, m);
            end
            tick();
        end
    endtask

    initial begin
        #1;
        test_reset();
        drain();
        test_latency_stall();
        drain();
        test_unused_operand();
        drain();
        test_youngest();
        drain();
        test_drain();
        drain();
        test_back_to_back();
        test_mid_reset();
        drain();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, want finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
